// File: rtl/rob_queue.sv
// Reorder buffer: in-order allocate, out-of-order status writeback, in-order retire.
// Latency: writeback at edge M is retirable in cycle M+1; allocation stalls (alloc_ready_out low) when free slots < DISPATCH_W or during a flush.
package rob_pkg;
    typedef enum logic [2:0] {
        READY     = 3'd0,
        ISSUED    = 3'd1,
        DONE      = 3'd2,
        EXCEPTION = 3'd3,
        INTERRUPT = 3'd4,
        TRAP      = 3'd5
    } status_t;
endpackage

module rob_queue #(
    parameter int ENTRIES    = 128,
    parameter int DISPATCH_W = 2,
    parameter int WB_PORTS   = 3,
    parameter int COMMIT_W   = 2,
    parameter int PAYLOAD_W  = 64,
    localparam int PTR_W     = $clog2(ENTRIES)
) (
    input  logic                                 clk_in,
    input  logic                                 rst_N_in,
    input  logic [DISPATCH_W-1:0]                alloc_valid_in,
    input  logic [DISPATCH_W-1:0][PAYLOAD_W-1:0] alloc_payload_in,
    output logic                                 alloc_ready_out,
    output logic [DISPATCH_W-1:0][PTR_W-1:0]     alloc_ptr_out,
    input  logic [WB_PORTS-1:0]                  wb_valid_in,
    input  logic [WB_PORTS-1:0][PTR_W-1:0]       wb_ptr_in,
    input  logic [WB_PORTS-1:0][2:0]             wb_status_in,
    output logic [COMMIT_W-1:0]                  commit_valid_out,
    output logic [COMMIT_W-1:0][PAYLOAD_W-1:0]   commit_payload_out,
    output logic [COMMIT_W-1:0][PTR_W-1:0]       commit_ptr_out,
    output logic [COMMIT_W-1:0][2:0]             commit_status_out,
    input  logic                                 commit_ready_in,
    input  logic                                 flush_valid_in,
    input  logic [PTR_W-1:0]                     flush_ptr_in,
    input  logic                                 flush_all_in,
    output logic [PTR_W:0]                       count_out,
    output logic                                 empty_out,
    output logic                                 full_out
);
    import rob_pkg::*;

    localparam logic [PTR_W:0] ONE       = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] ENT_CNT   = (PTR_W+1)'(ENTRIES);
    localparam logic [PTR_W:0] ALLOC_LIM = (PTR_W+1)'(ENTRIES - DISPATCH_W);

    logic [PTR_W:0]       head;
    logic [PTR_W:0]       tail;
    logic [PTR_W:0]       head_nxt;
    logic [PTR_W:0]       tail_nxt;
    logic [PTR_W:0]       count;
    logic [PTR_W:0]       alloc_num;
    logic [PTR_W:0]       commit_num;
    logic [WB_PORTS-1:0]  wb_live;
    logic [PTR_W-1:0]     flush_off;

    status_t              status_mem  [ENTRIES];
    logic [PAYLOAD_W-1:0] payload_mem [ENTRIES];

    // Live means the slot's distance from head is below the occupancy.
    function automatic logic is_live(input logic [PTR_W-1:0] idx,
                                     input logic [PTR_W:0]   h,
                                     input logic [PTR_W:0]   cnt);
        logic [PTR_W-1:0] off;
        off = idx - h[PTR_W-1:0];
        return ({1'b0, off} < cnt);
    endfunction

    assign count     = tail - head;
    assign count_out = count;
    assign empty_out = (count == '0);
    assign full_out  = (count == ENT_CNT);

    assign alloc_ready_out = (count <= ALLOC_LIM) && !flush_valid_in && !flush_all_in;

    always_comb begin
        alloc_num = '0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            alloc_ptr_out[i] = tail[PTR_W-1:0] + PTR_W'(i);
            alloc_num        = alloc_num + {{PTR_W{1'b0}}, alloc_valid_in[i]};
        end
    end

    always_comb begin
        for (int p = 0; p < WB_PORTS; p++) begin
            wb_live[p] = wb_valid_in[p] && is_live(wb_ptr_in[p], head, count);
        end
    end

    // Commit window: lanes stay contiguous; only DONE lets the chain continue.
    always_comb begin
        logic             chain;
        logic             lane_ok;
        logic [PTR_W-1:0] slot;
        status_t          st;
        chain      = 1'b1;
        lane_ok    = 1'b0;
        slot       = '0;
        st         = READY;
        commit_num = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            slot    = head[PTR_W-1:0] + PTR_W'(i);
            st      = status_mem[slot];
            lane_ok = chain && ((PTR_W+1)'(i) < count) &&
                      (st inside {DONE, EXCEPTION, INTERRUPT, TRAP});
            chain   = lane_ok && (st == DONE);
            commit_valid_out[i]   = lane_ok;
            commit_ptr_out[i]     = slot;
            commit_status_out[i]  = st;
            commit_payload_out[i] = payload_mem[slot];
            commit_num            = commit_num + {{PTR_W{1'b0}}, lane_ok};
        end
    end

    assign flush_off = flush_ptr_in - head[PTR_W-1:0];

    always_comb begin
        head_nxt = commit_ready_in ? (head + commit_num) : head;
        tail_nxt = tail;
        if (flush_all_in) begin
            tail_nxt = head_nxt;
        end else if (flush_valid_in) begin
            // Flush offset is taken from the pre-cycle head so the named entry survives.
            tail_nxt = head + {1'b0, flush_off} + ONE;
        end else if (alloc_ready_out) begin
            tail_nxt = tail + alloc_num;
        end
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head_nxt;
            tail <= tail_nxt;
        end
    end

    // Later ports are written last so the highest port index wins a collision.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            for (int i = 0; i < ENTRIES; i++) begin
                status_mem[i] <= READY;
            end
        end else begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_live[p]) begin
                    status_mem[wb_ptr_in[p]] <= status_t'(wb_status_in[p]);
                end
            end
            if (alloc_ready_out) begin
                for (int i = 0; i < DISPATCH_W; i++) begin
                    if (alloc_valid_in[i]) begin
                        status_mem[alloc_ptr_out[i]] <= READY;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (alloc_ready_out) begin
            for (int i = 0; i < DISPATCH_W; i++) begin
                if (alloc_valid_in[i]) begin
                    payload_mem[alloc_ptr_out[i]] <= alloc_payload_in[i];
                end
            end
        end
    end

endmodule
